// File: rtl/mips_pkg.sv
// Shared constants for the MIPS memory/writeback slice: load/store opcodes,
// data widths and the canonical nop encoding.
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned BE_W   = 4;

    localparam logic [OP_W-1:0] OP_SW  = 6'b101011;
    localparam logic [OP_W-1:0] OP_SH  = 6'b101001;
    localparam logic [OP_W-1:0] OP_SB  = 6'b101000;
    localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
    localparam logic [OP_W-1:0] OP_LH  = 6'b100001;
    localparam logic [OP_W-1:0] OP_LHU = 6'b100101;
    localparam logic [OP_W-1:0] OP_LB  = 6'b100000;
    localparam logic [OP_W-1:0] OP_LBU = 6'b100100;

    // sll $0,$0,0
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/mem_wb_stage_if.sv
// M-stage inputs and W-stage outputs of the memory/writeback pipeline register.
interface mem_wb_stage_if;
    import mips_pkg::*;

    logic              Flush;
    logic [DATA_W-1:0] Instr_M;
    logic [DATA_W-1:0] ALU_Out_M;
    logic [DATA_W-1:0] WrData_M;
    logic [DATA_W-1:0] PC4_M;
    logic [DATA_W-1:0] PC_M;
    logic [REG_W-1:0]  Rx_M;

    logic [DATA_W-1:0] Instr_W;
    logic [DATA_W-1:0] ALU_Out_W;
    logic [DATA_W-1:0] DM_Out_W;
    logic [DATA_W-1:0] PC4_W;
    logic [DATA_W-1:0] PC_W;
    logic [REG_W-1:0]  Rx_W;

    modport master (
        output Flush, Instr_M, ALU_Out_M, WrData_M, PC4_M, PC_M, Rx_M,
        input  Instr_W, ALU_Out_W, DM_Out_W, PC4_W, PC_W, Rx_W
    );

    modport slave (
        input  Flush, Instr_M, ALU_Out_M, WrData_M, PC4_M, PC_M, Rx_M,
        output Instr_W, ALU_Out_W, DM_Out_W, PC4_W, PC_W, Rx_W
    );

endinterface

// File: rtl/dm_byte_ram.sv
// Word-organised data memory with per-byte write enables, asynchronous clear
// and a combinational read port.
module dm_byte_ram
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[ADDR_W'(i)] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_c = mem_q[idx_i];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage and M/W pipeline register: byte-enabled stores, extended loads,
// and a flushable register feeding writeback.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned DM_ADDR_W = 12
) (
    input  logic           Clk,
    input  logic           Rst,
    mem_wb_stage_if.slave  bus
);

    logic [OP_W-1:0]      opcode;
    logic [1:0]           lane;
    logic [DM_ADDR_W-1:0] word_idx;
    logic [BE_W-1:0]      be_c;
    logic [DATA_W-1:0]    wdata_c;
    logic [DATA_W-1:0]    rdata_c;
    logic [DATA_W-1:0]    load_c;
    logic [15:0]          rd_half;
    logic [7:0]           rd_byte;

    logic [DATA_W-1:0] instr_q,   instr_d;
    logic [DATA_W-1:0] alu_q,     alu_d;
    logic [DATA_W-1:0] dm_q,      dm_d;
    logic [DATA_W-1:0] pc4_q,     pc4_d;
    logic [DATA_W-1:0] pc_q,      pc_d;
    logic [REG_W-1:0]  rx_q,      rx_d;

    assign opcode   = bus.Instr_M[31:26];
    assign lane     = bus.ALU_Out_M[1:0];
    assign word_idx = bus.ALU_Out_M[DM_ADDR_W+1:2];

    // Store lane enables and lane-replicated write data; a flush kills the store.
    always_comb begin
        be_c    = '0;
        wdata_c = bus.WrData_M;
        if (!bus.Flush) begin
            unique case (opcode)
                OP_SW: be_c = 4'hF;
                OP_SH: begin
                    be_c    = bus.ALU_Out_M[1] ? 4'hC : 4'h3;
                    wdata_c = {2{bus.WrData_M[15:0]}};
                end
                OP_SB: begin
                    be_c    = BE_W'(1) << lane;
                    wdata_c = {4{bus.WrData_M[7:0]}};
                end
                default: be_c = '0;
            endcase
        end
    end

    dm_byte_ram #(
        .ADDR_W (DM_ADDR_W)
    ) u_ram (
        .Clk     (Clk),
        .Rst     (Rst),
        .be_i    (be_c),
        .idx_i   (word_idx),
        .wdata_i (wdata_c),
        .rdata_c (rdata_c)
    );

    // Lane selection and sign/zero extension of the read word.
    always_comb begin
        rd_half = bus.ALU_Out_M[1] ? rdata_c[31:16] : rdata_c[15:0];
        unique case (lane)
            2'd0:    rd_byte = rdata_c[7:0];
            2'd1:    rd_byte = rdata_c[15:8];
            2'd2:    rd_byte = rdata_c[23:16];
            default: rd_byte = rdata_c[31:24];
        endcase
        unique case (opcode)
            OP_LW:   load_c = rdata_c;
            OP_LH:   load_c = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_c = {16'h0, rd_half};
            OP_LB:   load_c = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_c = {24'h0, rd_byte};
            default: load_c = '0;
        endcase
    end

    always_comb begin
        instr_d = bus.Instr_M;
        alu_d   = bus.ALU_Out_M;
        dm_d    = load_c;
        pc4_d   = bus.PC4_M;
        pc_d    = bus.PC_M;
        rx_d    = bus.Rx_M;
        if (bus.Flush) begin
            instr_d = NOP_INSTR;
            alu_d   = '0;
            dm_d    = '0;
            pc4_d   = '0;
            pc_d    = '0;
            rx_d    = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            instr_q <= NOP_INSTR;
            alu_q   <= '0;
            dm_q    <= '0;
            pc4_q   <= '0;
            pc_q    <= '0;
            rx_q    <= '0;
        end else begin
            instr_q <= instr_d;
            alu_q   <= alu_d;
            dm_q    <= dm_d;
            pc4_q   <= pc4_d;
            pc_q    <= pc_d;
            rx_q    <= rx_d;
        end
    end

    assign bus.Instr_W   = instr_q;
    assign bus.ALU_Out_W = alu_q;
    assign bus.DM_Out_W  = dm_q;
    assign bus.PC4_W     = pc4_q;
    assign bus.PC_W      = pc_q;
    assign bus.Rx_W      = rx_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage: stores, extended loads, flush, reset, wrap.
module tb_mem_wb_stage;

    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.DM_ADDR_W(12)) dut (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [4:0] rx, input logic fl);
        bus.Instr_M   = {op, 26'h0};
        bus.ALU_Out_M = addr;
        bus.WrData_M  = wd;
        bus.PC_M      = pc;
        bus.PC4_M     = pc + 32'd4;
        bus.Rx_M      = rx;
        bus.Flush     = fl;
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(SW, 32'h0, 32'hDEADBEEF, 32'h40, 5'd3, 1'b0);
        repeat (3) step();
        checks++; if (bus.Instr_W   !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp %h", bus.Instr_W, 32'h0); end
        checks++; if (bus.ALU_Out_W !== 32'h0) begin errors++; $display("FAIL rst_alu got %h exp %h", bus.ALU_Out_W, 32'h0); end
        checks++; if (bus.DM_Out_W  !== 32'h0) begin errors++; $display("FAIL rst_dm got %h exp %h", bus.DM_Out_W, 32'h0); end
        checks++; if (bus.PC4_W     !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp %h", bus.PC4_W, 32'h0); end
        checks++; if (bus.PC_W      !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", bus.PC_W, 32'h0); end
        checks++; if (bus.Rx_W      !== 5'd0)  begin errors++; $display("FAIL rst_rx got %h exp %h", bus.Rx_W, 5'd0); end
        rst_n = 1'b1;
        drive(LW, 32'h0, 32'h0, 32'h44, 5'd2, 1'b0);
        step();
        checks++; if (bus.DM_Out_W !== 32'h0) begin errors++; $display("FAIL rst_mem_lw got %h exp %h", bus.DM_Out_W, 32'h0); end
        checks++; if (bus.Instr_W !== {LW, 26'h0}) begin errors++; $display("FAIL rst_release_instr got %h exp %h", bus.Instr_W, {LW, 26'h0}); end
    endtask

    task automatic test_sw_lw();
        drive(SW, 32'h10, 32'h12345678, 32'h100, 5'd0, 1'b0);
        step();
        checks++; if (bus.Instr_W  !== {SW, 26'h0}) begin errors++; $display("FAIL sw_instr got %h exp %h", bus.Instr_W, {SW, 26'h0}); end
        checks++; if (bus.DM_Out_W !== 32'h0) begin errors++; $display("FAIL sw_dm got %h exp %h", bus.DM_Out_W, 32'h0); end
        drive(LW, 32'h10, 32'h0, 32'h104, 5'd8, 1'b0);
        step();
        checks++; if (bus.DM_Out_W  !== 32'h12345678) begin errors++; $display("FAIL lw_data got %h exp %h", bus.DM_Out_W, 32'h12345678); end
        checks++; if (bus.Instr_W   !== {LW, 26'h0}) begin errors++; $display("FAIL lw_instr got %h exp %h", bus.Instr_W, {LW, 26'h0}); end
        checks++; if (bus.PC_W      !== 32'h104) begin errors++; $display("FAIL lw_pc got %h exp %h", bus.PC_W, 32'h104); end
        checks++; if (bus.PC4_W     !== 32'h108) begin errors++; $display("FAIL lw_pc4 got %h exp %h", bus.PC4_W, 32'h108); end
        checks++; if (bus.Rx_W      !== 5'd8) begin errors++; $display("FAIL lw_rx got %h exp %h", bus.Rx_W, 5'd8); end
        checks++; if (bus.ALU_Out_W !== 32'h10) begin errors++; $display("FAIL lw_alu got %h exp %h", bus.ALU_Out_W, 32'h10); end
    endtask

    task automatic test_byte();
        drive(SB, 32'h13, 32'h123456AB, 32'h108, 5'd0, 1'b0); step();
        drive(LW, 32'h10, 32'h0, 32'h10C, 5'd9, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'hAB345678) begin errors++; $display("FAIL sb_lw got %h exp %h", bus.DM_Out_W, 32'hAB345678); end
        drive(LB, 32'h13, 32'h0, 32'h110, 5'd9, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'hFFFFFFAB) begin errors++; $display("FAIL lb_neg got %h exp %h", bus.DM_Out_W, 32'hFFFFFFAB); end
        drive(LBU, 32'h13, 32'h0, 32'h114, 5'd9, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'h000000AB) begin errors++; $display("FAIL lbu got %h exp %h", bus.DM_Out_W, 32'h000000AB); end
        drive(LB, 32'h11, 32'h0, 32'h118, 5'd9, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'h00000056) begin errors++; $display("FAIL lb_pos got %h exp %h", bus.DM_Out_W, 32'h00000056); end
        drive(LBU, 32'h12, 32'h0, 32'h11C, 5'd9, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'h00000034) begin errors++; $display("FAIL lbu_lane2 got %h exp %h", bus.DM_Out_W, 32'h00000034); end
    endtask

    task automatic test_half();
        drive(SH, 32'h22, 32'hFFFF8001, 32'h200, 5'd0, 1'b0); step();
        drive(LH, 32'h22, 32'h0, 32'h204, 5'd10, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'hFFFF8001) begin errors++; $display("FAIL lh_neg got %h exp %h", bus.DM_Out_W, 32'hFFFF8001); end
        drive(LHU, 32'h22, 32'h0, 32'h208, 5'd10, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'h00008001) begin errors++; $display("FAIL lhu got %h exp %h", bus.DM_Out_W, 32'h00008001); end
        drive(LW, 32'h20, 32'h0, 32'h20C, 5'd10, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'h80010000) begin errors++; $display("FAIL sh_lw got %h exp %h", bus.DM_Out_W, 32'h80010000); end
        // Odd halfword address: bit 0 ignored, low half written.
        drive(SH, 32'h21, 32'h12347FFE, 32'h210, 5'd0, 1'b0); step();
        drive(LW, 32'h20, 32'h0, 32'h214, 5'd10, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'h80017FFE) begin errors++; $display("FAIL sh_odd got %h exp %h", bus.DM_Out_W, 32'h80017FFE); end
        drive(LH, 32'h20, 32'h0, 32'h218, 5'd10, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'h00007FFE) begin errors++; $display("FAIL lh_pos got %h exp %h", bus.DM_Out_W, 32'h00007FFE); end
    endtask

    task automatic test_flush();
        drive(SW, 32'h40, 32'h5A5A5A5A, 32'h300, 5'd7, 1'b1); step();
        checks++; if (bus.Instr_W   !== 32'h0) begin errors++; $display("FAIL fl_instr got %h exp %h", bus.Instr_W, 32'h0); end
        checks++; if (bus.Rx_W      !== 5'd0)  begin errors++; $display("FAIL fl_rx got %h exp %h", bus.Rx_W, 5'd0); end
        checks++; if (bus.ALU_Out_W !== 32'h0) begin errors++; $display("FAIL fl_alu got %h exp %h", bus.ALU_Out_W, 32'h0); end
        checks++; if (bus.PC_W      !== 32'h0) begin errors++; $display("FAIL fl_pc got %h exp %h", bus.PC_W, 32'h0); end
        checks++; if (bus.PC4_W     !== 32'h0) begin errors++; $display("FAIL fl_pc4 got %h exp %h", bus.PC4_W, 32'h0); end
        drive(LW, 32'h10, 32'h0, 32'h304, 5'd4, 1'b1); step();
        checks++; if (bus.DM_Out_W !== 32'h0) begin errors++; $display("FAIL fl_load got %h exp %h", bus.DM_Out_W, 32'h0); end
        drive(LW, 32'h40, 32'h0, 32'h308, 5'd4, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'h0) begin errors++; $display("FAIL fl_mem got %h exp %h", bus.DM_Out_W, 32'h0); end
    endtask

    task automatic test_wrap();
        drive(SW, 32'h4040, 32'hCAFEF00D, 32'h400, 5'd0, 1'b0); step();
        drive(LW, 32'h40, 32'h0, 32'h404, 5'd11, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap got %h exp %h", bus.DM_Out_W, 32'hCAFEF00D); end
    endtask

    task automatic test_nonmem();
        bus.Instr_M   = 32'h00A42820;  // add $5,$5,$4
        bus.ALU_Out_M = 32'h7;
        bus.WrData_M  = 32'hFFFFFFFF;
        bus.PC_M      = 32'h500;
        bus.PC4_M     = 32'h504;
        bus.Rx_M      = 5'd5;
        bus.Flush     = 1'b0;
        step();
        checks++; if (bus.ALU_Out_W !== 32'h7) begin errors++; $display("FAIL add_alu got %h exp %h", bus.ALU_Out_W, 32'h7); end
        checks++; if (bus.Rx_W      !== 5'd5) begin errors++; $display("FAIL add_rx got %h exp %h", bus.Rx_W, 5'd5); end
        checks++; if (bus.DM_Out_W  !== 32'h0) begin errors++; $display("FAIL add_dm got %h exp %h", bus.DM_Out_W, 32'h0); end
        checks++; if (bus.Instr_W   !== 32'h00A42820) begin errors++; $display("FAIL add_instr got %h exp %h", bus.Instr_W, 32'h00A42820); end
        drive(LW, 32'h4, 32'h0, 32'h508, 5'd6, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'h0) begin errors++; $display("FAIL add_mem got %h exp %h", bus.DM_Out_W, 32'h0); end
    endtask

    task automatic test_back_to_back();
        drive(SW, 32'h84, 32'h11223344, 32'h600, 5'd0, 1'b0); step();
        drive(SB, 32'h87, 32'h00000099, 32'h604, 5'd0, 1'b0); step();
        drive(LW, 32'h84, 32'h0, 32'h608, 5'd12, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'h99223344) begin errors++; $display("FAIL b2b_lw got %h exp %h", bus.DM_Out_W, 32'h99223344); end
        drive(LH, 32'h86, 32'h0, 32'h60C, 5'd12, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'hFFFF9922) begin errors++; $display("FAIL b2b_lh got %h exp %h", bus.DM_Out_W, 32'hFFFF9922); end
    endtask

    task automatic test_async_reset();
        drive(LW, 32'h10, 32'h0, 32'h700, 5'd13, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'hAB345678) begin errors++; $display("FAIL pre_arst got %h exp %h", bus.DM_Out_W, 32'hAB345678); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.DM_Out_W !== 32'h0) begin errors++; $display("FAIL arst_dm got %h exp %h", bus.DM_Out_W, 32'h0); end
        checks++; if (bus.PC_W     !== 32'h0) begin errors++; $display("FAIL arst_pc got %h exp %h", bus.PC_W, 32'h0); end
        step();
        rst_n = 1'b1;
        drive(LW, 32'h10, 32'h0, 32'h704, 5'd13, 1'b0); step();
        checks++; if (bus.DM_Out_W !== 32'h0) begin errors++; $display("FAIL arst_mem got %h exp %h", bus.DM_Out_W, 32'h0); end
        checks++; if (bus.PC_W     !== 32'h704) begin errors++; $display("FAIL arst_resume got %h exp %h", bus.PC_W, 32'h704); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sw_lw();
        test_byte();
        test_half();
        test_flush();
        test_wrap();
        test_nonmem();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
